// File: rtl/reaction_game_core.sv
// reaction_game_core
// Purpose: core of a reaction game. After a start press the player sits through
// a READY countdown, then a PLAY window in which hits score points and misses
// cost lives. Clearing every level wins, and running out of lives loses.
// Ports:
//   in_clk     sole clock, rising edge
//   reset      asynchronous active-high reset
//   start      start/restart button level (acts on its rising edge)
//   hit, miss  player buttons (act on their rising edges)
//   state      00 IDLE, 01 READY, 10 PLAY, 11 END
//   level      current level
//   life       remaining lives
//   hits       hits scored in the current level
//   time_left  seconds remaining in the current countdown
//   game_end   00 running/idle, 01 win, 10 lose
//   tick       one-cycle pulse per elapsed second
module reaction_game_core #(
  parameter int TICK_DIV       = 100000000,
  parameter int READY_SECS     = 5,
  parameter int ROUND_SECS     = 30,
  parameter int NUM_LEVELS     = 4,
  parameter int NUM_LIVES      = 3,
  parameter int HITS_PER_LEVEL = 5,
  localparam int LVW  = (NUM_LEVELS > 1) ? $clog2(NUM_LEVELS) : 1,
  localparam int LFW  = $clog2(NUM_LIVES + 1),
  localparam int HW   = $clog2(HITS_PER_LEVEL + 1),
  localparam int MAXT = (READY_SECS > ROUND_SECS) ? READY_SECS : ROUND_SECS,
  localparam int TW   = $clog2(MAXT + 1)
) (
  input  logic           in_clk,
  input  logic           reset,
  input  logic           start,
  input  logic           hit,
  input  logic           miss,
  output logic [1:0]     state,
  output logic [LVW-1:0] level,
  output logic [LFW-1:0] life,
  output logic [HW-1:0]  hits,
  output logic [TW-1:0]  time_left,
  output logic [1:0]     game_end,
  output logic           tick
);

  localparam int PW = $clog2(TICK_DIV);

  localparam logic [PW-1:0]  PRESC_MAX  = PW'(TICK_DIV - 1);
  localparam logic [TW-1:0]  READY_T    = TW'(READY_SECS);
  localparam logic [TW-1:0]  ROUND_T    = TW'(ROUND_SECS);
  localparam logic [LVW-1:0] LAST_LEVEL = LVW'(NUM_LEVELS - 1);
  localparam logic [LFW-1:0] FULL_LIFE  = LFW'(NUM_LIVES);
  localparam logic [HW-1:0]  HITS_MAX   = HW'(HITS_PER_LEVEL);

  localparam logic [1:0] GE_NONE = 2'b00;
  localparam logic [1:0] GE_WIN  = 2'b01;
  localparam logic [1:0] GE_LOSE = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_READY = 2'b01,
    S_PLAY  = 2'b10,
    S_END   = 2'b11
  } state_t;

  state_t         r_state;
  logic [LVW-1:0] r_level;
  logic [LFW-1:0] r_life;
  logic [HW-1:0]  r_hits;
  logic [TW-1:0]  r_timeLeft;
  logic [1:0]     r_gameEnd;
  logic           r_tick;
  logic [PW-1:0]  r_presc;
  logic           r_startQ;
  logic           r_hitQ;
  logic           r_missQ;

  logic           w_startEdge;
  logic           w_hitEdge;
  logic           w_missEdge;
  logic           w_tickNow;
  logic           w_timeout;
  logic           w_lastLife;
  logic [PW-1:0]  w_prescNext;
  logic [TW-1:0]  w_timeDec;
  logic [HW-1:0]  w_hitsInc;

  // Button history registers reset to 1, so a button held through reset
  // release never looks like a fresh press.
  assign w_startEdge = start & ~r_startQ;
  assign w_hitEdge   = hit   & ~r_hitQ;
  assign w_missEdge  = miss  & ~r_missQ;

  // The second boundary is the cycle in which the prescaler sits at its top
  // value; the registered tick output then rises together with the timer update.
  assign w_tickNow   = (r_presc == PRESC_MAX);
  assign w_prescNext = w_tickNow ? '0 : r_presc + PW'(1);
  assign w_timeout   = w_tickNow && (r_timeLeft == TW'(1));
  assign w_timeDec   = (w_tickNow && (r_timeLeft != '0)) ? r_timeLeft - TW'(1) : r_timeLeft;
  assign w_lastLife  = (r_life == LFW'(1));
  assign w_hitsInc   = r_hits + HW'(1);

  // Game FSM. Every output is a register written here. Whenever time_left is
  // reloaded the prescaler restarts from 0, so the new second is a full one.
  always_ff @(posedge in_clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_level    <= '0;
      r_life     <= FULL_LIFE;
      r_hits     <= '0;
      r_timeLeft <= '0;
      r_gameEnd  <= GE_NONE;
      r_tick     <= 1'b0;
      r_presc    <= '0;
      r_startQ   <= 1'b1;
      r_hitQ     <= 1'b1;
      r_missQ    <= 1'b1;
    end else begin
      r_startQ <= start;
      r_hitQ   <= hit;
      r_missQ  <= miss;
      r_tick   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_startEdge) begin
            r_state    <= S_READY;
            r_timeLeft <= READY_T;
            r_presc    <= '0;
          end
        end
        S_READY: begin
          r_tick     <= w_tickNow;
          r_presc    <= w_prescNext;
          r_timeLeft <= w_timeDec;
          // A press during the countdown is a false start and outranks the
          // countdown expiring in the same cycle.
          if (w_hitEdge || w_missEdge) begin
            if (w_lastLife) begin
              r_life    <= '0;
              r_state   <= S_END;
              r_gameEnd <= GE_LOSE;
            end else begin
              r_life     <= r_life - LFW'(1);
              r_timeLeft <= READY_T;
              r_presc    <= '0;
            end
          end else if (w_timeout) begin
            r_state    <= S_PLAY;
            r_timeLeft <= ROUND_T;
            r_presc    <= '0;
          end
        end
        S_PLAY: begin
          r_tick     <= w_tickNow;
          r_presc    <= w_prescNext;
          r_timeLeft <= w_timeDec;
          // Only one event per cycle: miss beats timeout, which beats hit.
          if (w_missEdge) begin
            if (w_lastLife) begin
              r_life    <= '0;
              r_state   <= S_END;
              r_gameEnd <= GE_LOSE;
            end else begin
              r_life <= r_life - LFW'(1);
            end
          end else if (w_timeout) begin
            r_hits <= '0;
            if (w_lastLife) begin
              r_life    <= '0;
              r_state   <= S_END;
              r_gameEnd <= GE_LOSE;
            end else begin
              r_life     <= r_life - LFW'(1);
              r_state    <= S_READY;
              r_timeLeft <= READY_T;
              r_presc    <= '0;
            end
          end else if (w_hitEdge) begin
            if (w_hitsInc == HITS_MAX) begin
              if (r_level == LAST_LEVEL) begin
                r_hits    <= w_hitsInc;
                r_state   <= S_END;
                r_gameEnd <= GE_WIN;
              end else begin
                r_level    <= r_level + LVW'(1);
                r_hits     <= '0;
                r_state    <= S_READY;
                r_timeLeft <= READY_T;
                r_presc    <= '0;
              end
            end else begin
              r_hits <= w_hitsInc;
            end
          end
        end
        S_END: begin
          // Everything is held, and only a start press begins a new game.
          if (w_startEdge) begin
            r_state    <= S_READY;
            r_level    <= '0;
            r_life     <= FULL_LIFE;
            r_hits     <= '0;
            r_gameEnd  <= GE_NONE;
            r_timeLeft <= READY_T;
            r_presc    <= '0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign state     = r_state;
  assign level     = r_level;
  assign life      = r_life;
  assign hits      = r_hits;
  assign time_left = r_timeLeft;
  assign game_end  = r_gameEnd;
  assign tick      = r_tick;

endmodule
